bcd_score_ctrl: RTL and testbench
=================================

// Module: bcd_score_ctrl
// PURPOSE
//  Score accumulator controller for the game datapath. Arbitrates score-add requests
//  from several requesters (enemy hit, stage bonus, ...) and applies each winner to a
//  packed-BCD score register. The add uses ONE shared single-digit bcd_adder
//  (IN_A, IN_B, CIN -> SUM, COUT), sequenced digit-serially, LSD first, one digit/cycle.
// PARAMETERS
//  NREQ    2  number of requesters (1..8)
//  DIGITS  4  BCD digits in score (score width = 4*DIGITS)
//  SAT     1  1: saturate at all-9s on overflow; 0: wrap modulo 10^DIGITS
// PORTS
//  Clk       in   1             system clock, all state on rising edge
//  Reset_n   in   1             asynchronous, active-low reset
//  req       in   NREQ          level request; hold until matching ack
//  add_val   in   NREQ*4*DIGITS packed BCD addend; requester i at slice i; stable while req[i]
//  ack       out  NREQ          1-cycle pulse; requester i's add has been committed
//  clear     in   1             synchronous score clear (new game)
//  score     out  4*DIGITS      packed-BCD running score
//  busy      out  1             high in every state except IDLE
//  overflow  out  1             sticky: an add carried out of the top digit
// BEHAVIOUR
//  - Reset (Reset_n=0, async): score=0, ack=0, busy=0, overflow=0, FSM=IDLE,
//    rr pointer=0, all work registers 0. Applies immediately, including mid-add.
//  - FSM: IDLE -> LOAD -> ADD (DIGITS cycles) -> COMMIT -> IDLE.
//    IDLE: if any req, grant round-robin starting at rr pointer; else stay.
//    LOAD: latch granted index and its add_val into operand reg; carry=0; digit idx=0.
//    ADD:  feed score digit[idx], operand digit[idx], carry into bcd_adder; write SUM
//          into result digit[idx]; carry<=COUT; idx++; leave after idx=DIGITS-1.
//    COMMIT: score<=result (or saturated value); ack[grant] pulses; rr<=grant+1 mod NREQ.
//  - Latency: req seen in IDLE at cycle T -> ack and score update at T+DIGITS+2.
//    Back-to-back: next grant no earlier than the cycle after COMMIT.
//  - Addend digits >9 are clamped to 9 before the adder; score digits are always valid.
//  - Overflow: final carry=1 in COMMIT sets overflow; SAT=1 -> score=all 9s;
//    SAT=0 -> score=result (wrapped). overflow clears only on reset or clear.
//  - clear: highest priority in every state; next edge score=0, overflow=0, FSM=IDLE,
//    in-flight add aborted with NO ack; its req stays pending and is re-arbitrated.
//    clear with no op in flight: same, FSM stays IDLE.
//  - req dropped before ack: add still completes and ack still pulses (no cancel).
//  - Only the granted requester's ack ever pulses; at most one ack bit high per cycle.
//  - rr pointer advances only on COMMIT; aborted grants do not advance it.
// TESTING
//  1 Reset, req[0] add_val=0x0125 -> ack[0] exactly 6 cycles after grant, score=0x0125, busy low after.
//  2 score=0x0199, add 0x0001 -> score=0x0200 (carry ripples through 2 digits), overflow=0.
//  3 score=0x9990, add 0x0015, SAT=1 -> score=0x9999, overflow=1; SAT=0 -> 0x0005, overflow=1.
//  4 req=2'b11 held, add 0x0001 each -> acks alternate 0,1,0,1; score +1 per commit.
//  5 clear asserted during ADD digit 2 -> no ack, score=0, overflow=0; pending req re-served, score=addend.
//  6 Reset_n low mid-ADD -> all outputs 0 asynchronously; add_val digit 0xA treated as 9.

Source files
------------

// File: rtl/bcd_score_ctrl.sv
// Round-robin score-add controller: adds the winner's packed-BCD addend into the score
// one digit per cycle through a single shared BCD digit adder, LSD first.

module bcd_adder (
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, in_a} + {1'b0, in_b} + {4'b0000, cin};
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      sum  = raw[3:0] + 4'd6;
      cout = 1'b1;
    end
  end
endmodule

module bcd_score_ctrl #(
  parameter int NREQ   = 2,
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*4*DIGITS-1:0] add_val,
  output logic [NREQ-1:0]          ack,
  input  logic                     clear,
  output logic [4*DIGITS-1:0]      score,
  output logic                     busy,
  output logic                     overflow
);
  localparam int W  = 4 * DIGITS;
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ADD, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr, grant, pick;
  logic            found;
  logic [W-1:0]    opnd, opnd_sel, result;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [3:0]      a_dig, b_raw, b_dig, s_dig;
  logic            c_out;
  int              j;

  // Scan from rr upward; iterating the offset downward lets the nearest requester win.
  always_comb begin
    pick  = rr;
    found = 1'b0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[GW'(j)]) begin
        pick  = GW'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    opnd_sel = '0;
    for (int r = 0; r < NREQ; r++)
      if (grant == GW'(r)) opnd_sel = add_val[W*r +: W];
  end

  always_comb begin
    a_dig = '0;
    b_raw = '0;
    for (int d = 0; d < DIGITS; d++)
      if (idx == IW'(d)) begin
        a_dig = score[4*d +: 4];
        b_raw = opnd[4*d +: 4];
      end
    b_dig = (b_raw > 4'd9) ? 4'd9 : b_raw;
  end

  bcd_adder u_adder (
    .in_a (a_dig),
    .in_b (b_dig),
    .cin  (carry),
    .sum  (s_dig),
    .cout (c_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LOAD;
      LOAD:    state_nxt = ADD;
      ADD:     if (idx == IW'(DIGITS - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // A clear landing on the commit cycle aborts the add, so it must also swallow the ack.
  always_comb begin
    ack = '0;
    if (state == COMMIT && !clear)
      for (int r = 0; r < NREQ; r++)
        if (grant == GW'(r)) ack[r] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      score    <= '0;
      overflow <= 1'b0;
      rr       <= '0;
      grant    <= '0;
      opnd     <= '0;
      result   <= '0;
      carry    <= 1'b0;
      idx      <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        score    <= '0;
        overflow <= 1'b0;
        carry    <= 1'b0;
        idx      <= '0;
      end else begin
        case (state)
          IDLE: if (found) grant <= pick;
          LOAD: begin
            opnd   <= opnd_sel;
            result <= '0;
            carry  <= 1'b0;
            idx    <= '0;
          end
          ADD: begin
            for (int d = 0; d < DIGITS; d++)
              if (idx == IW'(d)) result[4*d +: 4] <= s_dig;
            carry <= c_out;
            idx   <= idx + IW'(1);
          end
          COMMIT: begin
            if (carry) begin
              overflow <= 1'b1;
              score    <= SAT ? {DIGITS{4'h9}} : result;
            end else begin
              score <= result;
            end
            rr <= (grant == GW'(NREQ - 1)) ? '0 : grant + GW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bcd_score_ctrl.sv
// Directed bench for bcd_score_ctrl: saturating and wrapping instances share stimulus,
// expected acks/scores are queued per add and checked when each ack appears.

module tb_bcd_score_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] add_val = '0;
  logic        clear = 1'b0;
  logic [1:0]  ack_s, ack_w;
  logic [15:0] score_s, score_w;
  logic        busy_s, busy_w, ovf_s, ovf_w;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] sc_s;
    logic [15:0] sc_w;
    logic        ovf_s;
    logic        ovf_w;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   ms = 0, mw = 0;
  bit   mo_s = 1'b0, mo_w = 1'b0;

  always #5 clk = ~clk;

  bcd_score_ctrl #(.NREQ(2), .DIGITS(4), .SAT(1'b1)) u_sat (
    .Clk(clk), .Reset_n(rst_n), .req(req), .add_val(add_val), .ack(ack_s),
    .clear(clear), .score(score_s), .busy(busy_s), .overflow(ovf_s)
  );

  bcd_score_ctrl #(.NREQ(2), .DIGITS(4), .SAT(1'b0)) u_wrap (
    .Clk(clk), .Reset_n(rst_n), .req(req), .add_val(add_val), .ack(ack_w),
    .clear(clear), .score(score_w), .busy(busy_w), .overflow(ovf_w)
  );

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    int d;
    for (int i = 3; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int m = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_add(input int who, input logic [15:0] val);
    exp_t e;
    int v = bcd2int(val);
    ms = ms + v;
    mw = mw + v;
    if (ms > 9999) begin ms = 9999; mo_s = 1'b1; end
    if (mw > 9999) begin mw = mw - 10000; mo_w = 1'b1; end
    e.ack   = (who == 0) ? 2'b01 : 2'b10;
    e.sc_s  = int2bcd(ms);
    e.sc_w  = int2bcd(mw);
    e.ovf_s = mo_s;
    e.ovf_w = mo_w;
    e.lat   = 6;
    q.push_back(e);
  endtask

  task automatic wait_ack(input bit drop);
    int   n = 0;
    bit   seen = 1'b0;
    exp_t e = '{default: 0};
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (ack_s != 2'b00 || ack_w != 2'b00) seen = 1'b1;
    end
    if (q.size() > 0) e = q.pop_front();
    chk("ack_sat", 32'(ack_s), 32'(e.ack));
    chk("ack_wrap", 32'(ack_w), 32'(e.ack));
    chk("ack_latency", 32'(n), 32'(e.lat));
    if (drop) req = 2'b00;
    @(negedge clk);
    chk("ack_pulse", 32'(ack_s | ack_w), 32'(0));
    chk("score_sat", 32'(score_s), 32'(e.sc_s));
    chk("score_wrap", 32'(score_w), 32'(e.sc_w));
    chk("ovf_sat", 32'(ovf_s), 32'(e.ovf_s));
    chk("ovf_wrap", 32'(ovf_w), 32'(e.ovf_w));
    if (drop) chk("busy_idle", 32'(busy_s | busy_w), 32'(0));
  endtask

  task automatic do_add(input int who, input logic [15:0] val);
    if (who == 0) add_val[15:0] = val;
    else          add_val[31:16] = val;
    req = (who == 0) ? 2'b01 : 2'b10;
    expect_add(who, val);
    wait_ack(1'b1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ms = 0; mw = 0; mo_s = 1'b0; mo_w = 1'b0;
    chk("clear_score", 32'({score_s, score_w}), 32'(0));
    chk("clear_ovf", 32'({ovf_s, ovf_w}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_score", 32'({score_s, score_w}), 32'(0));
    chk("rst_ack", 32'({ack_s, ack_w}), 32'(0));
    chk("rst_busy_ovf", 32'({busy_s, busy_w, ovf_s, ovf_w}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with 6-cycle grant-to-ack latency
    do_add(0, 16'h0125);

    // Carry ripple 0x0199 + 1 -> 0x0200
    do_add(1, 16'h0074);
    do_add(0, 16'h0001);

    // Overflow: saturate vs wrap, then sticky overflow
    do_clear();
    do_add(1, 16'h9990);
    do_add(0, 16'h0015);
    do_add(1, 16'h0001);

    // Clear during ADD digit 2 aborts without ack; request is re-served
    add_val[31:16] = 16'h0042;
    req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ack_s | ack_w), 32'(0));
    end
    chk("abort_busy", 32'(busy_s & busy_w), 32'(1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ms = 0; mw = 0; mo_s = 1'b0; mo_w = 1'b0;
    chk("abort_ack", 32'(ack_s | ack_w), 32'(0));
    chk("abort_score", 32'({score_s, score_w}), 32'(0));
    chk("abort_ovf_busy", 32'({ovf_s, ovf_w, busy_s, busy_w}), 32'(0));
    expect_add(1, 16'h0042);
    wait_ack(1'b1);

    // Both requesting: grants alternate 0,1,0,1
    add_val = {16'h0001, 16'h0001};
    req = 2'b11;
    expect_add(0, 16'h0001);
    expect_add(1, 16'h0001);
    expect_add(0, 16'h0001);
    expect_add(1, 16'h0001);
    wait_ack(1'b0);
    wait_ack(1'b0);
    wait_ack(1'b0);
    wait_ack(1'b1);

    // Async reset mid-ADD
    add_val[15:0] = 16'h1111;
    req = 2'b01;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_s & busy_w), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_score", 32'({score_s, score_w}), 32'(0));
    chk("arst_ctl", 32'({ack_s, ack_w, busy_s, busy_w, ovf_s, ovf_w}), 32'(0));
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    ms = 0; mw = 0; mo_s = 1'b0; mo_w = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'({busy_s, busy_w, score_s, score_w}), 32'(0));

    // Addend digits above 9 clamp to 9
    do_add(0, 16'h0A0A);
    do_add(1, 16'hA9A9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
